// File: rtl/compare_sweep_checker.sv
// Exhaustive sweep engine for WIDTH-bit magnitude comparators: issues every (a, b) pair,
// checks two response channels (plus an optional golden model) and reports the results.
module compare_sweep_checker #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESP_LAT     = 0,
    parameter bit          CHECK_GOLDEN = 1'b1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             enable,
    input  logic [2:0]       resp_a,
    input  logic [2:0]       resp_b,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_b
);

    localparam int unsigned      DEPTH    = RESP_LAT + 1;
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OP_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] OP_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] golden_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_out_r;
    logic [WIDTH-1:0] b_out_r;
    logic             busy_r;
    logic             done_r;
    logic [CNT_W-1:0] err_count_r;
    logic             ff_valid_r;
    logic [WIDTH-1:0] ff_a_r;
    logic [WIDTH-1:0] ff_b_r;

    // Check pipeline: stage 0 holds the pair currently on a_out/b_out.
    logic             pipe_v_r [DEPTH];
    logic [WIDTH-1:0] pipe_a_r [DEPTH];
    logic [WIDTH-1:0] pipe_b_r [DEPTH];

    logic             start_s;
    logic             step_s;
    logic             check_s;
    logic             mismatch_s;
    logic             stop_s;
    logic             final_s;
    logic             last_issue_s;
    logic             issue_s;
    logic [WIDTH-1:0] a_next_s;
    logic [WIDTH-1:0] b_next_s;
    logic [WIDTH-1:0] end_a_s;
    logic [WIDTH-1:0] end_b_s;
    logic [2:0]       golden_s;

    // Control decode for the current cycle.
    always_comb begin
        start_s      = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        step_s       = enable && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
        end_a_s      = pipe_a_r[RESP_LAT];
        end_b_s      = pipe_b_r[RESP_LAT];
        golden_s     = golden_cmp(end_a_s, end_b_s);
        check_s      = step_s && pipe_v_r[RESP_LAT];
        mismatch_s   = check_s && ((resp_a != resp_b) || (CHECK_GOLDEN && (resp_a != golden_s)));
        stop_s       = STOP_ON_FAIL && mismatch_s;
        final_s      = check_s && (end_a_s == ALL_ONES) && (end_b_s == ALL_ONES);
        a_next_s     = a_out_r + OP_ONE;
        if (a_out_r == ALL_ONES) begin
            b_next_s = b_out_r + OP_ONE;
        end else begin
            b_next_s = b_out_r;
        end
        last_issue_s = step_s && (state_r == ST_RUN) && (a_next_s == ALL_ONES) && (b_out_r == ALL_ONES);
        issue_s      = step_s && (state_r == ST_RUN) && !stop_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_s = ST_RUN;
                else       state_s = state_r;
            end
            ST_RUN: begin
                if (stop_s)            state_s = ST_DONE;
                else if (last_issue_s) state_s = ST_DRAIN;
                else                   state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (stop_s || final_s) state_s = ST_DONE;
                else                   state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Stimulus counter: a is the low digit, b advances on a's wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_out_r <= OP_ZERO;
            b_out_r <= OP_ZERO;
        end else if (start_s) begin
            a_out_r <= OP_ZERO;
            b_out_r <= OP_ZERO;
        end else if (issue_s) begin
            a_out_r <= a_next_s;
            b_out_r <= b_next_s;
        end
    end

    // Check pipeline: delays each issued pair to line up with its response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_v_r[i] <= 1'b0;
                pipe_a_r[i] <= OP_ZERO;
                pipe_b_r[i] <= OP_ZERO;
            end
        end else if (start_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_v_r[i] <= (i == 0);
                pipe_a_r[i] <= OP_ZERO;
                pipe_b_r[i] <= OP_ZERO;
            end
        end else if (stop_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_v_r[i] <= 1'b0;
            end
        end else if (step_s) begin
            pipe_v_r[0] <= issue_s;
            pipe_a_r[0] <= issue_s ? a_next_s : a_out_r;
            pipe_b_r[0] <= issue_s ? b_next_s : b_out_r;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_a_r[i] <= pipe_a_r[i-1];
                pipe_b_r[i] <= pipe_b_r[i-1];
            end
        end
    end

    // Error count (saturating) and first-failure capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_r <= CNT_ZERO;
            ff_valid_r  <= 1'b0;
            ff_a_r      <= OP_ZERO;
            ff_b_r      <= OP_ZERO;
        end else if (start_s) begin
            err_count_r <= CNT_ZERO;
            ff_valid_r  <= 1'b0;
            ff_a_r      <= OP_ZERO;
            ff_b_r      <= OP_ZERO;
        end else if (mismatch_s) begin
            if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + CNT_ONE;
            end
            if (!ff_valid_r) begin
                ff_valid_r <= 1'b1;
                ff_a_r     <= end_a_s;
                ff_b_r     <= end_b_s;
            end
        end
    end

    assign a_out            = a_out_r;
    assign b_out            = b_out_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = done_r && (err_count_r == CNT_ZERO);
    assign err_count        = err_count_r;
    assign first_fail_valid = ff_valid_r;
    assign first_fail_a     = ff_a_r;
    assign first_fail_b     = ff_b_r;

endmodule

// File: tb/tb_compare_sweep_checker.sv
// Directed bench: three sweep engines (default, stop-on-fail, response latency 2)
// driven by behavioural comparators with optional planted faults.
module tb_compare_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [2:0] cmp(input logic [3:0] a, input logic [3:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // ---------------- default instance ----------------
    logic        start0, en0;
    logic [2:0]  ra0, rb0;
    logic [3:0]  a0, b0, ffa0, ffb0;
    logic        busy0, done0, pass0, ffv0;
    logic [15:0] err0;
    int          fault0 = 0;

    always_comb begin
        ra0 = cmp(a0, b0);
        rb0 = cmp(a0, b0);
        if (fault0 == 1 && a0 == 4'd3 && b0 == 4'd5) rb0[1] = ~rb0[1];
    end

    compare_sweep_checker dut0 (
        .clk(clk), .reset(reset), .start(start0), .enable(en0),
        .resp_a(ra0), .resp_b(rb0), .a_out(a0), .b_out(b0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_valid(ffv0), .first_fail_a(ffa0), .first_fail_b(ffb0)
    );

    // ---------------- stop-on-fail instance ----------------
    logic        start_s, en_s;
    logic [2:0]  ra_s, rb_s;
    logic [3:0]  a_s, b_s, ffa_s, ffb_s;
    logic        busy_s, done_s, pass_s, ffv_s;
    logic [15:0] err_s;

    always_comb begin
        ra_s = cmp(a_s, b_s);
        rb_s = cmp(a_s, b_s);
        if ((a_s == 4'd2 && b_s == 4'd0) || (a_s == 4'd7 && b_s == 4'd1)) rb_s = rb_s ^ 3'b100;
    end

    compare_sweep_checker #(.STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .enable(en_s),
        .resp_a(ra_s), .resp_b(rb_s), .a_out(a_s), .b_out(b_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_fail_valid(ffv_s), .first_fail_a(ffa_s), .first_fail_b(ffb_s)
    );

    // ---------------- latency-2 instance ----------------
    logic        start_l, en_l;
    logic [2:0]  ra_l, rb_l;
    logic [2:0]  d1a = 3'b000, d2a = 3'b000, d1b = 3'b000, d2b = 3'b000;
    logic [3:0]  a_l, b_l, ffa_l, ffb_l;
    logic        busy_l, done_l, pass_l, ffv_l;
    logic [15:0] err_l;

    always @(posedge clk) begin
        d1a <= cmp(a_l, b_l);
        d2a <= d1a;
        d1b <= cmp(a_l, b_l);
        d2b <= d1b;
    end
    assign ra_l = d2a;
    assign rb_l = d2b;

    compare_sweep_checker #(.RESP_LAT(2), .CHECK_GOLDEN(1'b1)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .enable(en_l),
        .resp_a(ra_l), .resp_b(rb_l), .a_out(a_l), .b_out(b_l),
        .busy(busy_l), .done(done_l), .pass(pass_l), .err_count(err_l),
        .first_fail_valid(ffv_l), .first_fail_a(ffa_l), .first_fail_b(ffb_l)
    );

    task automatic test_reset();
        reset = 1'b1; start0 = 1'b0; start_s = 1'b0; start_l = 1'b0;
        en0 = 1'b1; en_s = 1'b1; en_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, err0, ffv0, ffa0, ffb0} !== 36'd0) begin
            failures++; $display("FAIL reset_dut0: got %h want 0", {a0, b0, busy0, done0, pass0, err0, ffv0, ffa0, ffb0});
        end
        checks++;
        if ({a_s, b_s, busy_s, done_s, pass_s, err_s, ffv_s, ffa_s, ffb_s} !== 36'd0) begin
            failures++; $display("FAIL reset_dut_s: got %h want 0", {a_s, b_s, busy_s, done_s, pass_s, err_s, ffv_s, ffa_s, ffb_s});
        end
        checks++;
        if ({a_l, b_l, busy_l, done_l, pass_l, err_l, ffv_l, ffa_l, ffb_l} !== 36'd0) begin
            failures++; $display("FAIL reset_dut_l: got %h want 0", {a_l, b_l, busy_l, done_l, pass_l, err_l, ffv_l, ffa_l, ffb_l});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_clean_sweep();
        int edges = -1;
        fault0 = 0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b1) begin failures++; $display("FAIL clean_busy: got %b want 1", busy0); end
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin edges = n; break; end
        end
        checks++;
        if (edges != 256) begin failures++; $display("FAIL clean_done_edge: got %0d want 256", edges); end
        checks++;
        if ({pass0, err0, ffv0, busy0} !== {1'b1, 16'd0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL clean_result: pass=%b err=%0d ffv=%b busy=%b want 1 0 0 0", pass0, err0, ffv0, busy0);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({done0, pass0} !== 2'b11) begin failures++; $display("FAIL clean_done_hold: got %b want 11", {done0, pass0}); end
    endtask

    task automatic test_first_fail();
        int edges = -1;
        fault0 = 1;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        checks++;
        if ({done0, busy0} !== 2'b01) begin failures++; $display("FAIL ff_restart: done,busy=%b want 01", {done0, busy0}); end
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin edges = n; break; end
        end
        checks++;
        if (edges != 256) begin failures++; $display("FAIL ff_done_edge: got %0d want 256", edges); end
        checks++;
        if ({err0, ffv0, ffa0, ffb0, pass0} !== {16'd1, 1'b1, 4'd3, 4'd5, 1'b0}) begin
            failures++; $display("FAIL ff_result: err=%0d ffv=%b a=%0d b=%0d pass=%b want 1 1 3 5 0", err0, ffv0, ffa0, ffb0, pass0);
        end
        fault0 = 0;
    endtask

    task automatic test_pause();
        int edges = -1;
        bit hold_bad = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin edges = n; break; end
            if (n >= 40 && n <= 50 && (a0 !== 4'd8 || b0 !== 4'd2)) hold_bad = 1'b1;
            if (n == 40) en0 = 1'b0;
            if (n == 50) en0 = 1'b1;
        end
        checks++;
        if (hold_bad) begin failures++; $display("FAIL pause_hold: operands moved, last a=%0d b=%0d want 8 2", a0, b0); end
        checks++;
        if (edges != 266) begin failures++; $display("FAIL pause_done_edge: got %0d want 266", edges); end
        checks++;
        if ({err0, pass0} !== {16'd0, 1'b1}) begin failures++; $display("FAIL pause_result: err=%0d pass=%b want 0 1", err0, pass0); end
    endtask

    task automatic test_reset_mid();
        int edges = -1;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks++;
        if ({a0, b0} !== {4'd4, 4'd6}) begin failures++; $display("FAIL mid_pair100: got a=%0d b=%0d want 4 6", a0, b0); end
        reset = 1'b1;
        #1;
        checks++;
        if ({a0, b0, busy0, done0, pass0, err0, ffv0, ffa0, ffb0} !== 36'd0) begin
            failures++; $display("FAIL mid_reset_clear: got %h want 0", {a0, b0, busy0, done0, pass0, err0, ffv0, ffa0, ffb0});
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) begin edges = n; break; end
        end
        checks++;
        if (edges != 256 || pass0 !== 1'b1) begin failures++; $display("FAIL mid_restart: edge=%0d pass=%b want 256 1", edges, pass0); end
    endtask

    task automatic test_stop_on_fail();
        int edges = -1;
        @(negedge clk); start_s = 1'b1;
        @(posedge clk); #1; start_s = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done_s === 1'b1) begin edges = n; break; end
        end
        checks++;
        if (edges != 3) begin failures++; $display("FAIL stop_done_edge: got %0d want 3", edges); end
        checks++;
        if ({err_s, ffv_s, ffa_s, ffb_s, pass_s} !== {16'd1, 1'b1, 4'd2, 4'd0, 1'b0}) begin
            failures++; $display("FAIL stop_result: err=%0d ffv=%b a=%0d b=%0d pass=%b want 1 1 2 0 0", err_s, ffv_s, ffa_s, ffb_s, pass_s);
        end
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if ({a_s, b_s, err_s, done_s} !== {4'd2, 4'd0, 16'd1, 1'b1}) begin
            failures++; $display("FAIL stop_hold: a=%0d b=%0d err=%0d done=%b want 2 0 1 1", a_s, b_s, err_s, done_s);
        end
    endtask

    task automatic test_resp_lat();
        int edges = -1;
        @(negedge clk); start_l = 1'b1;
        @(posedge clk); #1; start_l = 1'b0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (done_l === 1'b1) begin edges = n; break; end
            start_l = (n == 49);
        end
        start_l = 1'b0;
        checks++;
        if (edges != 258) begin failures++; $display("FAIL lat_done_edge: got %0d want 258", edges); end
        checks++;
        if ({err_l, ffv_l, pass_l} !== {16'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL lat_result: err=%0d ffv=%b pass=%b want 0 0 1", err_l, ffv_l, pass_l);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_first_fail();
        test_pause();
        test_reset_mid();
        test_stop_on_fail();
        test_resp_lat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/compare_sweep_checker.md
# compare_sweep_checker

Parametrised, self-checking exhaustive sweep engine for WIDTH-bit magnitude comparators. It drives every (a, b) operand pair onto two comparator instances, a reference channel and a channel under test. It checks their 3-bit {gt, eq, lt} responses against each other and, optionally, against a built-in golden model, then reports error count, the first failing pair and pass/fail. It replaces the free-running counter pair plus mismatch gating used in comparator benches, and adds a start/done handshake, pause, response latency and stop-on-fail.

## Interface
- WIDTH, 4, operand width; sweep covers N = 2^(2·WIDTH) pairs
- CNT_W, 16, error counter width (saturating)
- RESP_LAT, 0, extra register stages in the DUT response path (0..7)
- CHECK_GOLDEN, 1, 1 = also compare resp_a against the internal golden model
- STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  begin a sweep (sampled in IDLE/DONE only)
- enable  in  1  0 = pause: stimulus and check pipeline frozen
- resp_a  in  3  reference channel {gt, eq, lt}
- resp_b  in  3  channel under test {gt, eq, lt}
- a_out  out  WIDTH  operand A to both DUTs
- b_out  out  WIDTH  operand B to both DUTs
- busy  out  1  high in RUN/DRAIN
- done  out  1  high in DONE until next start
- pass  out  1  done && err_count == 0
- err_count  out  CNT_W  mismatches found, saturates at 2^CNT_W−1
- first_fail_valid  out  1  first_fail_a/b hold a captured pair
- first_fail_a  out  WIDTH  A of first failing pair
- first_fail_b  out  WIDTH  B of first failing pair

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1: clear err_count, first_fail_*, and the check pipeline; a_out=b_out=0; go to RUN.
- RUN: on each enabled edge, a_out increments. On a_out wrap (all ones → 0), b_out increments. The order matches the ripple-carry counter chain. The edge that issues a=b=all ones moves the FSM to DRAIN, and the stimulus holds.
- Check pipeline: per issued pair, the valid bit, a and b are delayed RESP_LAT+1 enabled edges. At the end of the pipeline, resp_a/resp_b are sampled against that pair.
- Golden model: {a>b, a==b, a<b} of the delayed pair.
- Mismatch: (resp_a != resp_b) | (CHECK_GOLDEN & (resp_a != golden)).
- On mismatch: err_count increments, saturating. If first_fail_valid=0, the delayed pair is captured and first_fail_valid is set.
- DRAIN → DONE on the edge that checks the final pair.
- STOP_ON_FAIL=1: the first mismatch goes to DONE on the same edge; remaining pipeline entries are discarded, and the stimulus holds.
- start while busy is ignored. enable=0 in IDLE/DONE has no effect on start.
- Simultaneous final-pair check and mismatch: count and capture apply, then DONE.

## Timing
- Reset values: all outputs 0, state IDLE, pipeline empty. Reset asserted mid-sweep aborts immediately to these values.
- Number edges from the start-sampling edge (edge 0). Pair k is driven after edge k and checked at edge k+1+RESP_LAT, with no pauses.
- busy=1 after edge 0. done=1 after edge N+RESP_LAT, with err_count/first_fail final on that same edge.
- Every enabled-low cycle delays all subsequent events by exactly one cycle.
- pass is combinational from done and err_count.

## Test plan
- WIDTH=4, RESP_LAT=0, both channels fed by correct comparators, start pulse → done after edge 256, err_count=0, pass=1, first_fail_valid=0.
- Same setup, resp_b eq bit forced wrong only at (a=3, b=5) → err_count=1, first_fail_a=3, first_fail_b=5, pass=0.
- STOP_ON_FAIL=1, resp_b wrong at (a=2, b=0) and (a=7, b=1) → done after edge 3, err_count=1, first fail (2,0).
- enable held low for 10 cycles around pair 40 → done after edge 266, err_count=0, a_out/b_out unchanged during the pause.
- reset pulse at pair 100 → all outputs 0 and busy=0 at once. A new start then completes at edge 256 with pass=1.
- RESP_LAT=2, DUT responses delayed 2 registers, CHECK_GOLDEN=1 → done after edge 258, err_count=0; a start pulse issued during RUN is ignored.
